// File: rtl/pulse_sequencer.sv
// Timed-segment pulse sequencer: fetches words from synchronous RAM and drives NCH
// channels, with trigger waits, a hardware loop stack, jumps and error reporting.
module pulse_sequencer #(
  parameter int              ADDR_SIZE  = 15,
  parameter int              NCH        = 64,
  parameter int              DW         = 20,
  parameter int              TW         = 32,
  parameter int              LOOP_DEPTH = 4,
  parameter logic [NCH-1:0]  IDLE_VALUE = {NCH{1'b0}}
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     run,
  input  logic                     trigger,
  input  logic [NCH+4+DW+TW-1:0]   mem_input,
  output logic [ADDR_SIZE-1:0]     mem_addr,
  output logic [NCH-1:0]           channels,
  output logic [3:0]               status,
  output logic                     start_monitor
);

  localparam int SP_W  = $clog2(LOOP_DEPTH + 1);
  localparam int IDX_W = (LOOP_DEPTH > 1) ? $clog2(LOOP_DEPTH) : 1;

  localparam logic [3:0] OP_CONT = 4'd0;
  localparam logic [3:0] OP_STOP = 4'd1;
  localparam logic [3:0] OP_WAIT = 4'd2;
  localparam logic [3:0] OP_LOOP = 4'd3;
  localparam logic [3:0] OP_LEND = 4'd4;
  localparam logic [3:0] OP_JUMP = 4'd5;

  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_RUN      = 4'd1;
  localparam logic [3:0] ST_WAIT     = 4'd2;
  localparam logic [3:0] ST_DONE     = 4'd3;
  localparam logic [3:0] ST_ERR_OP   = 4'd4;
  localparam logic [3:0] ST_ERR_STK  = 4'd5;
  localparam logic [3:0] ST_ERR_ADDR = 4'd6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_TRIG,
    S_DONE,
    S_ERR
  } state_t;

  state_t                 state_q;
  logic                   run_q;
  logic                   trigger_q;
  logic [ADDR_SIZE-1:0]   addr_q;
  logic [NCH-1:0]         chan_q;
  logic [3:0]             status_q;
  logic                   smon_q;
  logic [TW-1:0]          tcnt_q;
  logic [3:0]             op_q;
  logic [SP_W-1:0]        sp_q;

  logic [ADDR_SIZE-1:0]   stk_addr_q [LOOP_DEPTH];
  logic [DW-1:0]          stk_cnt_q  [LOOP_DEPTH];

  // Fields of the word currently presented by the RAM (address addr_q).
  logic [NCH-1:0]         w_flg;
  logic [3:0]             w_op;
  logic [DW-1:0]          w_data;
  logic [TW-1:0]          w_time;

  assign w_flg  = mem_input[TW+DW+4 +: NCH];
  assign w_op   = mem_input[TW+DW +: 4];
  assign w_data = mem_input[TW +: DW];
  assign w_time = mem_input[TW-1:0];

  logic run_edge;
  logic trig_edge;
  logic seg_end;
  logic at_end;
  logic stk_full;
  logic stk_empty;
  logic [IDX_W-1:0] push_idx;
  logic [IDX_W-1:0] top_idx;

  assign run_edge  = run & ~run_q;
  assign trig_edge = trigger & ~trigger_q;
  assign seg_end   = (tcnt_q == '0);
  assign at_end    = &addr_q;
  assign stk_full  = (sp_q == SP_W'(LOOP_DEPTH));
  assign stk_empty = (sp_q == '0);
  assign push_idx  = sp_q[IDX_W-1:0];
  assign top_idx   = IDX_W'(sp_q - SP_W'(1));

  logic [3:0]           err_d;
  logic [ADDR_SIZE-1:0] addr_d;
  logic [TW-1:0]        tlen_d;
  logic [DW-1:0]        loop_cnt_d;
  logic                 push_d;
  logic                 pop_d;
  logic                 dec_d;
  logic                 apply_d;
  logic                 accept_d;

  // Decode of the prefetched word: next address, stack action and any error.
  always_comb begin
    err_d      = ST_IDLE;
    addr_d     = addr_q + ADDR_SIZE'(1);
    tlen_d     = (w_time < TW'(2)) ? TW'(1) : (w_time - TW'(1));
    loop_cnt_d = (w_data == '0) ? DW'(1) : w_data;
    push_d     = 1'b0;
    pop_d      = 1'b0;
    dec_d      = 1'b0;
    case (w_op)
      OP_CONT, OP_WAIT: begin
        if (at_end) err_d = ST_ERR_ADDR;
      end
      OP_STOP: ;
      OP_LOOP: begin
        if (stk_full)    err_d  = ST_ERR_STK;
        else if (at_end) err_d  = ST_ERR_ADDR;
        else             push_d = 1'b1;
      end
      OP_LEND: begin
        if (stk_empty) begin
          err_d = ST_ERR_STK;
        end else if (stk_cnt_q[top_idx] > DW'(1)) begin
          dec_d  = 1'b1;
          addr_d = stk_addr_q[top_idx];
        end else begin
          pop_d = 1'b1;
        end
      end
      OP_JUMP: addr_d = w_data[ADDR_SIZE-1:0];
      default: err_d = ST_ERR_OP;
    endcase
  end

  // A new word is taken on the first cycle after the start, at the end of a plain
  // segment, or on a trigger edge while waiting.
  always_comb begin
    apply_d = 1'b0;
    case (state_q)
      S_FETCH: apply_d = 1'b1;
      S_EXEC:  apply_d = seg_end && (op_q != OP_STOP) && (op_q != OP_WAIT);
      S_TRIG:  apply_d = trig_edge;
      default: apply_d = 1'b0;
    endcase
  end

  assign accept_d = run && apply_d && (err_d == ST_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      run_q     <= 1'b0;
      trigger_q <= 1'b0;
      addr_q    <= '0;
      chan_q    <= IDLE_VALUE;
      status_q  <= ST_IDLE;
      smon_q    <= 1'b0;
      tcnt_q    <= '0;
      op_q      <= OP_CONT;
      sp_q      <= '0;
    end else begin
      run_q     <= run;
      trigger_q <= trigger;
      smon_q    <= 1'b0;
      if (!run) begin
        state_q  <= S_IDLE;
        addr_q   <= '0;
        chan_q   <= IDLE_VALUE;
        status_q <= ST_IDLE;
        sp_q     <= '0;
      end else if (apply_d) begin
        if (err_d != ST_IDLE) begin
          // Faulting word is never applied; channels keep the last segment.
          state_q  <= S_ERR;
          status_q <= err_d;
        end else begin
          state_q  <= S_EXEC;
          status_q <= ST_RUN;
          chan_q   <= w_flg;
          tcnt_q   <= tlen_d;
          op_q     <= w_op;
          addr_q   <= addr_d;
          smon_q   <= (state_q == S_FETCH);
          if (push_d) sp_q <= sp_q + SP_W'(1);
          if (pop_d)  sp_q <= sp_q - SP_W'(1);
        end
      end else begin
        case (state_q)
          S_IDLE: begin
            if (run_edge) begin
              state_q  <= S_FETCH;
              status_q <= ST_RUN;
            end
          end
          S_EXEC: begin
            if (!seg_end) begin
              tcnt_q <= tcnt_q - TW'(1);
            end else if (op_q == OP_STOP) begin
              state_q  <= S_DONE;
              status_q <= ST_DONE;
            end else begin
              state_q  <= S_TRIG;
              status_q <= ST_WAIT;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Loop stack storage needs no reset: only entries below sp_q are ever read.
  always_ff @(posedge clk) begin
    if (accept_d && push_d) begin
      stk_addr_q[push_idx] <= addr_q + ADDR_SIZE'(1);
      stk_cnt_q[push_idx]  <= loop_cnt_d;
    end else if (accept_d && dec_d) begin
      stk_cnt_q[top_idx] <= stk_cnt_q[top_idx] - DW'(1);
    end
  end

  assign mem_addr      = addr_q;
  assign channels      = chan_q;
  assign status        = status_q;
  assign start_monitor = smon_q;

endmodule

// File: tb/tb_pulse_sequencer.sv
// Bench for pulse_sequencer: an instruction-level interpreter predicts the per-cycle
// channels/status/start_monitor trace, checked every cycle, plus literal pins.
module tb_pulse_sequencer;

  localparam int NCH  = 64;
  localparam int DW   = 20;
  localparam int TW   = 32;
  localparam int AS   = 15;
  localparam int WW   = NCH + 4 + DW + TW;
  localparam int H    = 100;
  localparam int MAXA = (1 << AS) - 1;
  localparam int DEPTH = 4;

  localparam logic [3:0] OP_CONT = 4'd0;
  localparam logic [3:0] OP_STOP = 4'd1;
  localparam logic [3:0] OP_WAIT = 4'd2;
  localparam logic [3:0] OP_LOOP = 4'd3;
  localparam logic [3:0] OP_LEND = 4'd4;
  localparam logic [3:0] OP_JUMP = 4'd5;
  localparam logic [3:0] OP_BAD  = 4'd9;

  logic            clk;
  logic            reset;
  logic            run;
  logic            trigger;
  logic [WW-1:0]   mem_input;
  logic [AS-1:0]   mem_addr;
  logic [NCH-1:0]  channels;
  logic [3:0]      status;
  logic            start_monitor;

  pulse_sequencer #(
    .ADDR_SIZE(AS), .NCH(NCH), .DW(DW), .TW(TW), .LOOP_DEPTH(DEPTH), .IDLE_VALUE('0)
  ) dut (
    .clk(clk), .reset(reset), .run(run), .trigger(trigger), .mem_input(mem_input),
    .mem_addr(mem_addr), .channels(channels), .status(status), .start_monitor(start_monitor)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [WW-1:0] mem [0:MAXA];
  always @(posedge clk) mem_input <= mem[mem_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [NCH-1:0] exp_ch [H];
  logic [3:0]     exp_st [H];
  logic           exp_sm [H];

  int    n_tests = 0;
  int    n_fail  = 0;
  int    base    = 0;
  bit    checking = 1'b0;
  string cur_name = "none";
  int    sm_count = 0;
  int    hit_count = 0;
  logic [NCH-1:0] hit_val = '1;
  int    trig_at [4];
  int    n_trig = 0;
  int    cidx;

  function automatic logic [WW-1:0] mk(input logic [NCH-1:0] f, input logic [3:0] o,
                                       input logic [DW-1:0] d, input logic [TW-1:0] t);
    return {f, o, d, t};
  endfunction

  task automatic pin(input string nm, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, got, want);
    end
  endtask

  task automatic fill(input int from, input logic [NCH-1:0] ch, input int st);
    for (int i = (from < 0 ? 0 : from); i < H; i++) begin
      exp_ch[i] = ch;
      exp_st[i] = 4'(st);
      exp_sm[i] = 1'b0;
    end
  endtask

  // Instruction-level interpreter: walks the program and lays segments onto the timeline.
  task automatic model_run(input int r);
    int t, pc, sp, L, c, nxt, data, err;
    int saddr [8];
    int scnt  [8];
    longint tm;
    logic [WW-1:0]  w;
    logic [NCH-1:0] flg, last;
    logic [3:0]     op;
    bit first;
    fill(r + 1, '0, 1);
    t = r + 2; pc = 0; sp = 0; first = 1'b1; last = '0;
    for (int guard = 0; guard < 1000 && t < H; guard++) begin
      w    = mem[pc];
      flg  = w[WW-1 -: NCH];
      op   = w[DW+TW +: 4];
      data = int'(w[TW +: DW]);
      tm   = longint'(w[TW-1:0]);
      err  = 0;
      case (op)
        OP_CONT, OP_WAIT: if (pc == MAXA) err = 6;
        OP_STOP, OP_JUMP: ;
        OP_LOOP: if (sp == DEPTH) err = 5; else if (pc == MAXA) err = 6;
        OP_LEND: if (sp == 0) err = 5;
        default: err = 4;
      endcase
      if (err != 0) begin
        fill(t, last, err);
        return;
      end
      L = (tm < 2) ? 2 : int'(tm);
      for (int i = 0; i < L; i++) begin
        if (t + i < H) begin
          exp_ch[t+i] = flg;
          exp_st[t+i] = 4'd1;
          exp_sm[t+i] = (i == 0) && first;
        end
      end
      first = 1'b0; last = flg; t = t + L; nxt = pc + 1;
      case (op)
        OP_STOP: begin
          fill(t, last, 3);
          return;
        end
        OP_WAIT: begin
          c = -1;
          for (int k = 0; k < n_trig; k++) if (c < 0 && trig_at[k] >= t) c = trig_at[k];
          fill(t, last, 2);
          if (c < 0) return;
          t = c + 1;
        end
        OP_LOOP: begin
          saddr[sp] = pc + 1;
          scnt[sp]  = (data == 0) ? 1 : data;
          sp++;
        end
        OP_LEND: begin
          if (scnt[sp-1] > 1) begin
            scnt[sp-1]--;
            nxt = saddr[sp-1];
          end else begin
            sp--;
          end
        end
        OP_JUMP: nxt = data % (MAXA + 1);
        default: ;
      endcase
      pc = nxt;
    end
  endtask

  function automatic bit is_trig(input int rel);
    for (int k = 0; k < n_trig; k++) if (trig_at[k] == rel) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int count_exp(input logic [NCH-1:0] v);
    int n = 0;
    for (int i = 0; i < H; i++) if (exp_ch[i] == v) n++;
    return n;
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) mem[i] = '0;
    mem[MAXA] = '0;
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    reset = 1'b0; run = 1'b0; trigger = 1'b0;
    @(posedge clk); #2;
    @(posedge clk); #2;
    reset = 1'b1;
  endtask

  // Run a, abort at a1 (H = never), optional restart at r2 (-1 = none).
  task automatic run_test(input string nm, input int r1, input int a1, input int r2);
    do_reset();
    base = cyc;
    pin({nm, "_reset_addr"}, 64'(mem_addr), 64'd0);
    fill(0, '0, 0);
    model_run(r1);
    if (a1 < H) fill(a1 + 1, '0, 0);
    if (r2 >= 0) model_run(r2);
    cur_name = nm; sm_count = 0; hit_count = 0; checking = 1'b1;
    for (int rel = 0; rel < H; rel++) begin
      run     = (rel >= r1 && rel < a1) || (r2 >= 0 && rel >= r2);
      trigger = is_trig(rel);
      @(posedge clk); #2;
    end
    checking = 1'b0;
    $display("[TB] %s: %0d cycles traced, %0d start pulses", nm, H, sm_count);
  endtask

  always @(negedge clk) begin
    if (checking) begin
      cidx = cyc - base;
      if (cidx >= 0 && cidx < H) begin
        n_tests++;
        if (start_monitor) sm_count++;
        if (channels == hit_val) hit_count++;
        if (channels !== exp_ch[cidx] || status !== exp_st[cidx] || start_monitor !== exp_sm[cidx]) begin
          n_fail++;
          $display("FAIL %s trace cycle %0d: channels=%0h status=%0d smon=%0b, required channels=%0h status=%0d smon=%0b",
                   cur_name, cidx, channels, status, start_monitor, exp_ch[cidx], exp_st[cidx], exp_sm[cidx]);
        end
      end
    end
  end

  task automatic load_nested();
    clear_mem();
    mem[0] = mk(64'h1,   OP_LOOP, 20'd3, 32'd2);
    mem[1] = mk(64'h2,   OP_LOOP, 20'd2, 32'd2);
    mem[2] = mk(64'h80,  OP_CONT, 20'd0, 32'd4);
    mem[3] = mk(64'h4,   OP_LEND, 20'd0, 32'd2);
    mem[4] = mk(64'h8,   OP_LEND, 20'd0, 32'd2);
    mem[5] = mk(64'h10,  OP_LOOP, 20'd0, 32'd2);
    mem[6] = mk(64'h20,  OP_CONT, 20'd0, 32'd3);
    mem[7] = mk(64'h40,  OP_LEND, 20'd0, 32'd2);
    mem[8] = mk(64'h100, OP_STOP, 20'd0, 32'd2);
  endtask

  initial begin
    reset = 1'b0; run = 1'b0; trigger = 1'b0;
    clear_mem();

    // Basic timing
    mem[0] = mk(64'hA, OP_CONT, 20'd0, 32'd5);
    mem[1] = mk(64'h5, OP_CONT, 20'd0, 32'd3);
    mem[2] = mk(64'h1, OP_STOP, 20'd0, 32'd2);
    run_test("basic", 3, H, -1);
    pin("basic_model_first",  64'(exp_ch[5]),  64'hA);
    pin("basic_model_prestart", 64'(exp_ch[4]), 64'h0);
    pin("basic_model_a_end",  64'(exp_ch[9]),  64'hA);
    pin("basic_model_second", 64'(exp_ch[10]), 64'h5);
    pin("basic_model_third",  64'(exp_ch[13]), 64'h1);
    pin("basic_model_done",   64'(exp_st[15]), 64'd3);
    pin("basic_smon_pulses",  64'(sm_count),   64'd1);

    // Minimum clamp
    clear_mem();
    mem[0] = mk(64'h11, OP_CONT, 20'd0, 32'd0);
    mem[1] = mk(64'h22, OP_CONT, 20'd0, 32'd1);
    mem[2] = mk(64'h33, OP_CONT, 20'd0, 32'd2);
    mem[3] = mk(64'h44, OP_STOP, 20'd0, 32'd0);
    run_test("clamp", 3, H, -1);
    pin("clamp_model_t0",   64'(exp_ch[6]),  64'h11);
    pin("clamp_model_t1",   64'(exp_ch[7]),  64'h22);
    pin("clamp_model_t2",   64'(exp_ch[9]),  64'h33);
    pin("clamp_model_done", 64'(exp_st[13]), 64'd3);

    // Trigger wait: pulses at start, during EXEC (ignored), then the real one
    clear_mem();
    mem[0] = mk(64'hF, OP_WAIT, 20'd0, 32'd2);
    mem[1] = mk(64'h3, OP_CONT, 20'd0, 32'd4);
    mem[2] = mk(64'h7, OP_STOP, 20'd0, 32'd2);
    trig_at[0] = 3; trig_at[1] = 5; trig_at[2] = 17; n_trig = 3;
    run_test("trigger", 3, H, -1);
    n_trig = 0;
    pin("trig_model_exec",  64'(exp_st[6]),  64'd1);
    pin("trig_model_wait",  64'(exp_st[17]), 64'd2);
    pin("trig_model_hold",  64'(exp_ch[17]), 64'hF);
    pin("trig_model_next",  64'(exp_ch[18]), 64'h3);
    pin("trig_model_done",  64'(exp_st[24]), 64'd3);

    // Nested loops
    load_nested();
    hit_val = 64'h80;
    run_test("loops", 3, H, -1);
    pin("loops_model_inner", 64'(count_exp(64'h80)), 64'd24);
    pin("loops_model_once",  64'(count_exp(64'h20)), 64'd3);
    pin("loops_model_last",  64'(exp_st[63]), 64'd1);
    pin("loops_model_done",  64'(exp_st[64]), 64'd3);
    pin("loops_dut_inner",   64'(hit_count),  64'd24);

    // Bad opcode
    clear_mem();
    mem[0] = mk(64'h5, OP_CONT, 20'd0, 32'd3);
    mem[1] = mk(64'h6, OP_BAD,  20'd0, 32'd3);
    run_test("err_opcode", 3, H, -1);
    pin("errop_model_status", 64'(exp_st[8]), 64'd4);
    pin("errop_model_hold",   64'(exp_ch[8]), 64'h5);

    // Stack overflow
    clear_mem();
    for (int i = 0; i < 5; i++) mem[i] = mk(64'(i + 1), OP_LOOP, 20'd2, 32'd2);
    run_test("err_push", 3, H, -1);
    pin("push_model_status", 64'(exp_st[13]), 64'd5);
    pin("push_model_hold",   64'(exp_ch[13]), 64'h4);

    // Stack underflow
    clear_mem();
    mem[0] = mk(64'h9, OP_LEND, 20'd0, 32'd2);
    run_test("err_pop", 3, H, -1);
    pin("pop_model_status", 64'(exp_st[5]), 64'd5);
    pin("pop_dut_nostart",  64'(sm_count),  64'd0);

    // Address wrap
    clear_mem();
    mem[0]    = mk(64'h9, OP_JUMP, 20'h7FFF, 32'd2);
    mem[MAXA] = mk(64'hC, OP_CONT, 20'd0,    32'd2);
    run_test("err_addr", 3, H, -1);
    pin("addr_model_status", 64'(exp_st[7]), 64'd6);
    pin("addr_model_hold",   64'(exp_ch[7]), 64'h9);

    // Abort mid-segment, then restart without reset
    load_nested();
    run_test("abort", 3, 20, 30);
    pin("abort_model_before", 64'(exp_ch[20]), 64'h4);
    pin("abort_model_ch",     64'(exp_ch[21]), 64'h0);
    pin("abort_model_st",     64'(exp_st[21]), 64'd0);
    pin("abort_model_first",  64'(exp_ch[32]), 64'h1);
    pin("abort_model_smon",   64'(exp_sm[32]), 64'd1);
    pin("abort_dut_pulses",   64'(sm_count),   64'd2);

    // Asynchronous reset mid-loop
    do_reset();
    for (int rel = 0; rel < 20; rel++) begin
      run = (rel >= 3);
      @(posedge clk); #2;
    end
    pin("areset_pre_active", 64'(channels != '0), 64'd1);
    reset = 1'b0;
    #1;
    pin("areset_channels", 64'(channels),      64'h0);
    pin("areset_status",   64'(status),        64'd0);
    pin("areset_smon",     64'(start_monitor), 64'd0);
    pin("areset_addr",     64'(mem_addr),      64'd0);
    run = 1'b0;
    $display("[TB] async reset applied mid-loop");
    run_test("restart", 3, H, -1);
    pin("restart_dut_inner", 64'(hit_count), 64'd24);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
